// File: rtl/store_pkg.sv
// Shared definitions for the store-path alignment unit.
//   - size encodings for req_size (log2 of the access byte count)
//   - FSM state encoding
//   - helpers deriving lane count and lane-offset width from the bus width
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE,
        ERR
    } state_e;

    // Number of byte lanes on a bus of data_w bits.
    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Width of the byte offset within one bus word.
    function automatic int unsigned off_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane shifter.
// Builds the byte-enable mask and lane-aligned data over two bus words
// (2*NB lanes) so that a boundary-crossing store falls out naturally as a
// low half (beat 0) and a high half (beat 1).
//   size : access size, log2 of byte count
//   off  : byte offset within the bus word
//   data : right-justified store data
//   mask : 2*NB-bit byte mask, ((1<<n)-1) << off
//   wide : 2*DATA_W-bit data, data[8n-1:0] << 8*off
module store_lane_shifter
    import store_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                          size,
    input  logic [off_bits(DATA_W)-1:0]         off,
    input  logic [DATA_W-1:0]                   data,
    output logic [2*lane_count(DATA_W)-1:0]     mask,
    output logic [2*DATA_W-1:0]                 wide
);

    localparam int unsigned NB = lane_count(DATA_W);

    logic [2*NB-1:0]     base_mask;
    logic [2*DATA_W-1:0] base_data;

    always_comb begin
        base_mask = '0;
        base_data = '0;
        // Only the low n bytes are kept; an oversize request is truncated
        // to NB lanes, which is harmless because it is rejected upstream.
        for (int unsigned i = 0; i < NB; i++) begin
            if (i < (32'd1 << size)) begin
                base_mask[i]         = 1'b1;
                base_data[8*i +: 8]  = data[8*i +: 8];
            end
        end
        mask = base_mask << off;
        wide = base_data << {off, 3'b000};
    end

endmodule

// File: rtl/store_align_unit.sv
// Store-path unit between the memory stage and a word-addressed data bus.
// Converts a store request into one or two bus beats with byte enables and
// lane-aligned data. Boundary-crossing stores are split (SPLIT_EN=1) or
// rejected (SPLIT_EN=0); oversize accesses are always rejected.
//   clk, reset       : clock, asynchronous active-low reset
//   req_valid/ready  : request handshake (ready only in IDLE)
//   req_size/addr/data : store request, captured at acceptance
//   bus_valid/ready  : bus beat handshake
//   bus_addr/be/wdata: beat payload, zero when no beat is presented
//   done, err        : one-cycle completion / rejection pulses
module store_align_unit
    import store_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_size,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [DATA_W/8-1:0]  bus_be,
    output logic [DATA_W-1:0]    bus_wdata,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned NB = lane_count(DATA_W);
    localparam int unsigned OB = off_bits(DATA_W);

    state_e state, state_next;

    logic [1:0]          cap_size;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_data;

    logic [2*NB-1:0]     mask;
    logic [2*DATA_W-1:0] wide;
    logic [ADDR_W-1:0]   base_addr;

    logic [31:0]         req_off;
    logic [31:0]         req_n;
    logic                illegal;
    logic                accept;

    assign accept = req_valid && (state == IDLE);

    // Legality is judged on the raw request so the ERR decision is made in
    // the acceptance cycle; crossing is off + n > NB.
    always_comb begin
        req_off = 32'(req_addr[OB-1:0]);
        req_n   = 32'd1 << req_size;
        illegal = (32'(req_size) > OB) || (!SPLIT_EN && ((req_off + req_n) > NB));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_size <= '0;
            cap_addr <= '0;
            cap_data <= '0;
        end else if (accept) begin
            cap_size <= req_size;
            cap_addr <= req_addr;
            cap_data <= req_data;
        end
    end

    store_lane_shifter #(
        .DATA_W (DATA_W)
    ) u_shift (
        .size (cap_size),
        .off  (cap_addr[OB-1:0]),
        .data (cap_data),
        .mask (mask),
        .wide (wide)
    );

    assign base_addr = {cap_addr[ADDR_W-1:OB], {OB{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = illegal ? ERR : BEAT0;
            BEAT0:   if (bus_ready) state_next = (|mask[2*NB-1:NB]) ? BEAT1 : DONE;
            BEAT1:   if (bus_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode only registered state and captured fields, so there is
    // no path from req_* or bus_ready to any output.
    always_comb begin
        req_ready = (state == IDLE);
        bus_valid = (state == BEAT0) || (state == BEAT1);
        done      = (state == DONE);
        err       = (state == ERR);
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (state == BEAT0) begin
            bus_addr  = base_addr;
            bus_be    = mask[NB-1:0];
            bus_wdata = wide[DATA_W-1:0];
        end else if (state == BEAT1) begin
            bus_addr  = base_addr + ADDR_W'(NB);
            bus_be    = mask[2*NB-1:NB];
            bus_wdata = wide[2*DATA_W-1:DATA_W];
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: a 32-bit splitting instance driven
// from a vector table, plus a 32-bit non-splitting and a 64-bit instance
// exercised by short hand-written sequences.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        bus_ready = 1'b1;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;

    logic        a_ready, a_bvalid, a_done, a_err;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        b_ready, b_bvalid, b_done, b_err;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        c_ready, c_bvalid, c_done, c_err;
    logic [31:0] c_addr;
    logic [63:0] c_wdata;
    logic [7:0]  c_be;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(valid_a), .req_ready(a_ready),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data[31:0]),
        .bus_valid(a_bvalid), .bus_ready(bus_ready), .bus_addr(a_addr),
        .bus_be(a_be), .bus_wdata(a_wdata), .done(a_done), .err(a_err));

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(valid_b), .req_ready(b_ready),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data[31:0]),
        .bus_valid(b_bvalid), .bus_ready(bus_ready), .bus_addr(b_addr),
        .bus_be(b_be), .bus_wdata(b_wdata), .done(b_done), .err(b_err));

    store_align_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_EN(1'b1)) dut_c (
        .clk(clk), .reset(reset), .req_valid(valid_c), .req_ready(c_ready),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .bus_valid(c_bvalid), .bus_ready(bus_ready), .bus_addr(c_addr),
        .bus_be(c_be), .bus_wdata(c_wdata), .done(c_done), .err(c_err));

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_err;
        bit          two;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), 64'(a_ready), 64'd1);
        req_size = v.size;
        req_addr = v.addr;
        req_data = {32'd0, v.data};
        valid_a  = 1'b1;
        @(negedge clk);
        valid_a  = 1'b0;
        if (v.is_err) begin
            check($sformatf("v%0d_err", idx), 64'(a_err), 64'd1);
            check($sformatf("v%0d_err_bvalid", idx), 64'(a_bvalid), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_err_ready", idx), 64'(a_ready), 64'd1);
            check($sformatf("v%0d_err_bvalid2", idx), 64'(a_bvalid), 64'd0);
            check($sformatf("v%0d_err_done", idx), 64'(a_done), 64'd0);
        end else begin
            check($sformatf("v%0d_bvalid0", idx), 64'(a_bvalid), 64'd1);
            check($sformatf("v%0d_ready0", idx), 64'(a_ready), 64'd0);
            check($sformatf("v%0d_addr0", idx), 64'(a_addr), 64'(v.a0));
            check($sformatf("v%0d_be0", idx), 64'(a_be), 64'(v.be0));
            check($sformatf("v%0d_wdata0", idx), 64'(a_wdata), 64'(v.w0));
            @(negedge clk);
            if (v.two) begin
                check($sformatf("v%0d_bvalid1", idx), 64'(a_bvalid), 64'd1);
                check($sformatf("v%0d_addr1", idx), 64'(a_addr), 64'(v.a1));
                check($sformatf("v%0d_be1", idx), 64'(a_be), 64'(v.be1));
                check($sformatf("v%0d_wdata1", idx), 64'(a_wdata), 64'(v.w1));
                @(negedge clk);
            end
            check($sformatf("v%0d_done", idx), 64'(a_done), 64'd1);
            check($sformatf("v%0d_no_err", idx), 64'(a_err), 64'd0);
            check($sformatf("v%0d_done_bvalid", idx), 64'(a_bvalid), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_ready_after", idx), 64'(a_ready), 64'd1);
            check($sformatf("v%0d_done_low", idx), 64'(a_done), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            size   addr           data          err two a0             be0    w0             a1            be1    w1
        vecs[0] = '{2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0,        4'h0, 32'h0};
        vecs[1] = '{2'd0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0000_1000, 4'h8, 32'hAB00_0000, 32'h0,        4'h0, 32'h0};
        vecs[2] = '{2'd1, 32'h0000_1003, 32'h0000_1234, 0, 1, 32'h0000_1000, 4'h8, 32'h3400_0000, 32'h0000_1004, 4'h1, 32'h0000_0012};
        vecs[3] = '{2'd3, 32'h0000_2000, 32'h0000_0000, 1, 0, 32'h0,         4'h0, 32'h0,         32'h0,        4'h0, 32'h0};
        vecs[4] = '{2'd1, 32'h0000_1002, 32'hFFFF_5678, 0, 0, 32'h0000_1000, 4'hC, 32'h5678_0000, 32'h0,        4'h0, 32'h0};
        vecs[5] = '{2'd0, 32'h0000_1001, 32'h1234_56CD, 0, 0, 32'h0000_1000, 4'h2, 32'h0000_CD00, 32'h0,        4'h0, 32'h0};
        vecs[6] = '{2'd2, 32'h0000_1001, 32'h1122_3344, 0, 1, 32'h0000_1000, 4'hE, 32'h2233_4400, 32'h0000_1004, 4'h1, 32'h0000_0011};
        vecs[7] = '{2'd2, 32'hFFFF_FFFE, 32'hAABB_CCDD, 0, 1, 32'hFFFF_FFFC, 4'hC, 32'hCCDD_0000, 32'h0000_0000, 4'h3, 32'h0000_AABB};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(a_ready), 64'd1);
        check("rst_bvalid", 64'(a_bvalid), 64'd0);
        check("rst_addr", 64'(a_addr), 64'd0);
        check("rst_be", 64'(a_be), 64'd0);
        check("rst_wdata", 64'(a_wdata), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Bus stall for 5 cycles in BEAT0: payload held, no new request taken
        @(negedge clk);
        bus_ready = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_3000;
        req_data  = 64'h0000_0000_0102_0304;
        valid_a   = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_bvalid", k), 64'(a_bvalid), 64'd1);
            check($sformatf("stall%0d_ready", k), 64'(a_ready), 64'd0);
            check($sformatf("stall%0d_addr", k), 64'(a_addr), 64'h3000);
            check($sformatf("stall%0d_be", k), 64'(a_be), 64'hF);
            check($sformatf("stall%0d_wdata", k), 64'(a_wdata), 64'h0102_0304);
            if (k == 4) begin
                bus_ready = 1'b1;
                valid_a   = 1'b0;
            end
            @(negedge clk);
        end
        check("stall_done", 64'(a_done), 64'd1);
        @(negedge clk);
        check("stall_ready_after", 64'(a_ready), 64'd1);

        // Reset asserted during BEAT1: beat dropped, no done
        @(negedge clk);
        req_size = 2'd1;
        req_addr = 32'h0000_1003;
        req_data = 64'h1234;
        valid_a  = 1'b1;
        @(negedge clk);
        valid_a  = 1'b0;
        check("rb_beat0_be", 64'(a_be), 64'h8);
        @(negedge clk);
        check("rb_beat1_valid", 64'(a_bvalid), 64'd1);
        check("rb_beat1_be", 64'(a_be), 64'h1);
        reset = 1'b0;
        #1;
        check("rb_bvalid", 64'(a_bvalid), 64'd0);
        check("rb_ready", 64'(a_ready), 64'd1);
        check("rb_be", 64'(a_be), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rb_no_done%0d", k), 64'(a_done), 64'd0);
            @(negedge clk);
        end

        // Non-splitting instance: crossing half store is rejected
        req_size = 2'd1;
        req_addr = 32'h0000_1003;
        req_data = 64'h1234;
        valid_b  = 1'b1;
        @(negedge clk);
        valid_b  = 1'b0;
        check("ns_err", 64'(b_err), 64'd1);
        check("ns_bvalid", 64'(b_bvalid), 64'd0);
        check("ns_ready_busy", 64'(b_ready), 64'd0);
        @(negedge clk);
        check("ns_err_low", 64'(b_err), 64'd0);
        check("ns_ready", 64'(b_ready), 64'd1);
        check("ns_bvalid2", 64'(b_bvalid), 64'd0);
        check("ns_done", 64'(b_done), 64'd0);

        // Non-splitting instance: aligned word store still goes through
        req_size = 2'd2;
        req_addr = 32'h0000_1000;
        req_data = 64'hCAFE_F00D;
        valid_b  = 1'b1;
        @(negedge clk);
        valid_b  = 1'b0;
        check("ns_word_bvalid", 64'(b_bvalid), 64'd1);
        check("ns_word_be", 64'(b_be), 64'hF);
        check("ns_word_wdata", 64'(b_wdata), 64'hCAFE_F00D);
        @(negedge clk);
        check("ns_word_done", 64'(b_done), 64'd1);
        check("ns_word_no_err", 64'(b_err), 64'd0);

        // 64-bit instance: dword crossing with address wrap
        @(negedge clk);
        req_size = 2'd3;
        req_addr = 32'hFFFF_FFFC;
        req_data = 64'h1122_3344_5566_7788;
        valid_c  = 1'b1;
        @(negedge clk);
        valid_c  = 1'b0;
        check("w64_bvalid0", 64'(c_bvalid), 64'd1);
        check("w64_addr0", 64'(c_addr), 64'hFFFF_FFF8);
        check("w64_be0", 64'(c_be), 64'hF0);
        check("w64_wdata0", c_wdata, 64'h5566_7788_0000_0000);
        @(negedge clk);
        check("w64_bvalid1", 64'(c_bvalid), 64'd1);
        check("w64_addr1", 64'(c_addr), 64'h0);
        check("w64_be1", 64'(c_be), 64'h0F);
        check("w64_wdata1", c_wdata, 64'h0000_0000_1122_3344);
        @(negedge clk);
        check("w64_done", 64'(c_done), 64'd1);
        check("w64_no_err", 64'(c_err), 64'd0);
        @(negedge clk);
        check("w64_ready", 64'(c_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Parametrised store-path unit between the CPU's memory stage and the word-addressed data bus. It turns a store request into byte enables and lane-aligned write data, and generalises the fixed 32-bit byte-enable decoder to any power-of-two bus width and access size. It adds a valid/ready handshake on both sides. Stores that cross a bus-word boundary are either split into two bus beats or rejected with an address error, selected by parameter.

## Interface
- DATA_W, 32, bus data width in bits; a power of two, at least 32.
- ADDR_W, 32, byte-address width.
- SPLIT_EN, 1, 1 = split boundary-crossing stores into two beats; 0 = flag them as errors.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request.
- req_size  in  2  access size, log2 of the byte count: 0=byte, 1=half, 2=word, 3=dword.
- req_addr  in  ADDR_W  byte address.
- req_data  in  DATA_W  store data, right-justified.
- bus_valid  out  1  a bus beat is presented.
- bus_ready  in  1  bus accepts the beat.
- bus_addr  out  ADDR_W  bus-word-aligned beat address.
- bus_be  out  DATA_W/8  byte enables; bit i enables byte lane i.
- bus_wdata  out  DATA_W  lane-shifted data; disabled lanes are 0.
- done  out  1  one-cycle pulse when a store completes.
- err  out  1  one-cycle pulse when a store is rejected.

## Operation
- Derived values:
  - NB = DATA_W/8; OB = log2(NB).
  - off = req_addr[OB-1:0]; n = 1 << req_size.
- A request is accepted when req_valid && req_ready; all fields are captured into registers at acceptance.
- A 2*NB-bit mask is formed as ((1<<n)-1) << off, and a 2*DATA_W data value as req_data[8n-1:0] << (8*off).
  - Low halves of the mask and data form beat 0; high halves form beat 1.
  - Beat 0 address is req_addr with the low OB bits cleared; beat 1 address is beat 0 address + NB, wrapping modulo 2^ADDR_W.
- Error conditions:
  - req_size > OB is illegal and causes an error.
  - A non-zero beat-1 mask with SPLIT_EN=0 causes an error.
  - An erroring request produces no bus beat.
- State machine, with only IDLE having req_ready=1:
  - IDLE: on acceptance, go to ERR if the request is illegal, otherwise go to BEAT0.
  - BEAT0: bus_valid=1 with beat-0 payload. On bus_ready, go to BEAT1 if the beat-1 mask is non-zero, otherwise go to DONE.
  - BEAT1: bus_valid=1 with beat-1 payload. On bus_ready, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
  - ERR: err=1 for one cycle, then go to IDLE.
- The payload is registered and held stable while bus_valid=1 && !bus_ready.
- Reset at any time returns the FSM to IDLE and discards any in-flight beat. No partial completion is signalled.

## Timing
- Reset values: req_ready=1, bus_valid=0, bus_addr=0, bus_be=0, bus_wdata=0, done=0, err=0.
- Acceptance in cycle T puts bus_valid=1 in cycle T+1.
- A beat handshake in cycle H:
  - if a second beat is needed, beat 1 is presented in H+1;
  - on the final beat, done=1 in H+1 and req_ready=1 in H+2.
- An illegal request accepted in T gives err=1 in T+1 and req_ready=1 in T+2.
- Throughput at zero bus stall: 3 cycles per single-beat store, 4 per split store.
- Outputs are registered; there is no combinational path from req_* or bus_ready to any output.

## Structure
- Package store_pkg holds:
  - the size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - the state enum IDLE/BEAT0/BEAT1/DONE/ERR;
  - a function returning NB-derived widths.
- Sub-module store_lane_shifter is purely combinational: it takes (size, off, data) and produces (mask, shifted data) over 2*NB lanes. It is instantiated once, on the captured request.

## Test plan
- DATA_W=32, word store, addr 0x1000, data 0xDEADBEEF: one beat with addr 0x1000, be 1111, wdata 0xDEADBEEF. done pulses; no err.
- Byte store, addr 0x1003, data 0x000000AB: one beat with addr 0x1000, be 1000, wdata 0xAB000000.
- Half store, addr 0x1003, data 0x1234, SPLIT_EN=1, two beats:
  - beat 0: addr 0x1000, be 1000, wdata 0x34000000;
  - beat 1: addr 0x1004, be 0001, wdata 0x00000012;
  - done follows beat 1.
- Same request with SPLIT_EN=0, and separately req_size=3 with DATA_W=32: err=1 in T+1; bus_valid never asserts.
- bus_ready held low 5 cycles during BEAT0: bus_addr, bus_be and bus_wdata stay constant and req_ready stays 0. Asserting reset (low) during BEAT1 gives bus_valid=0 immediately, req_ready=1, and no done.
- DATA_W=64, dword store at addr 0xFFFFFFFC, SPLIT_EN=1:
  - beat 0: addr 0xFFFFFFF8, be 0xF0;
  - beat 1: addr 0x00000000 (wrapped), be 0x0F.
